mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / LSU) arbiter onto a shared memory port.
// Writes complete in one cycle; reads block the port until data returns or the timeout fires.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [63:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output logic [63:0] fetch_rdata,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [63:0] lsu_addr,
  input  logic [63:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [63:0] lsu_rdata,
  output logic        mem_ren,
  output logic [63:0] mem_raddr,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        mem_wen,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic        err
);

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;

  typedef enum logic {IDLE, WAIT_RD} state_t;
  typedef enum logic {REQ_FETCH, REQ_LSU} req_t;

  state_t          state, state_d;
  req_t            last_gnt, last_gnt_d;
  req_t            owner, owner_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            err_d;
  logic            mem_ren_d, mem_wen_d;
  logic [AW-1:0]   mem_raddr_d, mem_waddr_d;
  logic [DW-1:0]   mem_wdata_d;
  logic            fetch_rvalid_d, lsu_rvalid_d;
  logic [DW-1:0]   fetch_rdata_d, lsu_rdata_d;
  logic            ret_fire;
  logic [DW-1:0]   ret_data;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_gnt     <= REQ_LSU;
      owner        <= REQ_FETCH;
      cnt          <= '0;
      err          <= 1'b0;
      mem_ren      <= 1'b0;
      mem_raddr    <= '0;
      mem_wen      <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      fetch_rvalid <= 1'b0;
      fetch_rdata  <= '0;
      lsu_rvalid   <= 1'b0;
      lsu_rdata    <= '0;
    end else begin
      state        <= state_d;
      last_gnt     <= last_gnt_d;
      owner        <= owner_d;
      cnt          <= cnt_d;
      err          <= err_d;
      mem_ren      <= mem_ren_d;
      mem_raddr    <= mem_raddr_d;
      mem_wen      <= mem_wen_d;
      mem_waddr    <= mem_waddr_d;
      mem_wdata    <= mem_wdata_d;
      fetch_rvalid <= fetch_rvalid_d;
      fetch_rdata  <= fetch_rdata_d;
      lsu_rvalid   <= lsu_rvalid_d;
      lsu_rdata    <= lsu_rdata_d;
    end
  end

  // Next-state, grant and output logic
  always_comb begin
    state_d        = state;
    last_gnt_d     = last_gnt;
    owner_d        = owner;
    cnt_d          = cnt;
    err_d          = err;
    mem_ren_d      = 1'b0;
    mem_raddr_d    = mem_raddr;
    mem_wen_d      = 1'b0;
    mem_waddr_d    = mem_waddr;
    mem_wdata_d    = mem_wdata;
    fetch_rvalid_d = 1'b0;
    fetch_rdata_d  = fetch_rdata;
    lsu_rvalid_d   = 1'b0;
    lsu_rdata_d    = lsu_rdata;
    fetch_gnt      = 1'b0;
    lsu_gnt        = 1'b0;
    ret_fire       = 1'b0;
    ret_data       = '0;

    unique case (state)
      IDLE: begin
        // No read is outstanding, so any returned data here is spurious
        if (mem_rvalid) begin
          err_d = 1'b1;
        end
        fetch_gnt = fetch_req && (!lsu_req || (last_gnt == REQ_LSU));
        lsu_gnt   = lsu_req && !fetch_gnt;
        if (fetch_gnt) begin
          last_gnt_d  = REQ_FETCH;
          owner_d     = REQ_FETCH;
          mem_ren_d   = 1'b1;
          mem_raddr_d = fetch_addr;
          cnt_d       = '0;
          state_d     = WAIT_RD;
        end else if (lsu_gnt) begin
          last_gnt_d = REQ_LSU;
          if (lsu_we) begin
            mem_wen_d   = 1'b1;
            mem_waddr_d = lsu_addr;
            mem_wdata_d = lsu_wdata;
          end else begin
            owner_d     = REQ_LSU;
            mem_ren_d   = 1'b1;
            mem_raddr_d = lsu_addr;
            cnt_d       = '0;
            state_d     = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        cnt_d = cnt + CW'(1);
        // Real data takes priority over a timeout landing in the same cycle
        if (mem_rvalid) begin
          ret_fire = 1'b1;
          ret_data = mem_rdata;
          state_d  = IDLE;
        end else if (cnt == CW'(TIMEOUT)) begin
          ret_fire = 1'b1;
          ret_data = '0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ret_fire) begin
      if (owner == REQ_FETCH) begin
        fetch_rvalid_d = 1'b1;
        fetch_rdata_d  = ret_data;
      end else begin
        lsu_rvalid_d = 1'b1;
        lsu_rdata_d  = ret_data;
      end
    end
  end

endmodule
